// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and its sequencer:
// ALU operation codes, RV32 opcode / funct7 constants and the sequencer states.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I(+M) instruction-to-ALU-operation decoder.
// Illegal encodings always report ADD so the datapath sees a harmless op.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] code,
    output logic       is_muldiv,
    output logic       is_div,
    output logic       illegal
);

    // Map opcode class and function fields onto a single ALU operation
    always_comb begin
        code      = ALU_ADD;
        is_muldiv = 1'b0;
        is_div    = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL, OP_JALR: code = ALU_ADD;
            OP_LUI: code = ALU_PASSB;
            OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  code = ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        3'b101:  code = ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  code = ALU_SUB;
                        3'b101:  code = ALU_SRA;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
                    // M ops are laid out contiguously from MUL in funct3 order;
                    // funct3[2] separates the divide group from the multiplies.
                    code      = 5'(ALU_MUL) + {2'b00, funct3};
                    is_muldiv = 1'b1;
                    is_div    = funct3[2];
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ITYPE: begin
                // Immediate ops have no SUB; funct7 only qualifies the shifts.
                case (funct3)
                    3'b000: code = ALU_ADD;
                    3'b001: begin
                        if (funct7 == F7_BASE) code = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE)     code = ALU_SRL;
                        else if (funct7 == F7_ALT) code = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            code = ALU_ADD;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decoded ALU code on an accepted start,
// answers single-cycle ops with a done pulse, and for mul/div ops launches the
// iterative unit and holds busy for the configured number of cycles.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              is_muldiv,
    output logic              md_start,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [4:0]        dec_code;
    logic              dec_muldiv, dec_div, dec_illegal;
    logic [CTRL_W-1:0] alu_ctrl_nxt;
    logic              is_muldiv_nxt, md_start_nxt, busy_nxt, done_nxt, illegal_nxt;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .code      (dec_code),
        .is_muldiv (dec_muldiv),
        .is_div    (dec_div),
        .illegal   (dec_illegal)
    );

    // State, counter and all registered outputs; reset wins in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_ctrl  <= '0;
            is_muldiv <= 1'b0;
            md_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            alu_ctrl  <= alu_ctrl_nxt;
            is_muldiv <= is_muldiv_nxt;
            md_start  <= md_start_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            illegal   <= illegal_nxt;
        end
    end

    // Only an accepted mul/div op leaves IDLE; RUN ends when the count expires
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && dec_muldiv) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0)           state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; op fields are captured only on accept
    always_comb begin
        alu_ctrl_nxt  = alu_ctrl;
        is_muldiv_nxt = is_muldiv;
        illegal_nxt   = illegal;
        cnt_nxt       = cnt;
        md_start_nxt  = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    alu_ctrl_nxt  = CTRL_W'(dec_code);
                    is_muldiv_nxt = dec_muldiv;
                    illegal_nxt   = dec_illegal;
                    if (dec_muldiv) begin
                        md_start_nxt = 1'b1;
                        busy_nxt     = 1'b1;
                        cnt_nxt      = dec_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    done_nxt = 1'b1;
                end else begin
                    busy_nxt = 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: two instances (M extension on / off) share one
// stimulus stream; accepted ops are predicted as transactions and a separate
// monitor compares every output of both instances once per cycle.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [4:0] ctrl0;
    logic [6:0] ctrl1;
    logic [1:0] mdiv_o, mds_o, busy_o, done_o, ill_o;

    alu_ctrl_seq #(.CTRL_W(5), .ENABLE_M(1), .MUL_CYCLES(4), .DIV_CYCLES(32)) u_m_on (
        .clk(clk), .reset(reset), .start(start), .op(op), .funct3(funct3), .funct7(funct7),
        .alu_ctrl(ctrl0), .is_muldiv(mdiv_o[0]), .md_start(mds_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .illegal(ill_o[0])
    );

    alu_ctrl_seq #(.CTRL_W(7), .ENABLE_M(0), .MUL_CYCLES(3), .DIV_CYCLES(5)) u_m_off (
        .clk(clk), .reset(reset), .start(start), .op(op), .funct3(funct3), .funct7(funct7),
        .alu_ctrl(ctrl1), .is_muldiv(mdiv_o[1]), .md_start(mds_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .illegal(ill_o[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        bit         md;
        bit         ill;
        int         acc;     // edge at which the op is accepted
        int         done_e;  // edge after which done is visible
    } exp_t;

    exp_t       sbq [2][$];
    int         next_free [2];
    int         n_mul [2] = '{4, 3};
    int         n_div [2] = '{32, 5};
    bit         en_m  [2] = '{1'b1, 1'b0};
    logic [4:0] held_code [2];
    bit         held_md [2];
    bit         held_ill [2];
    int         edge_cnt = 0;
    int         last_e = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         stim_done = 1'b0;

    // Reference decode written straight from the instruction-set tables
    function automatic void ref_dec(input bit m_on, input logic [6:0] o, input logic [2:0] f3,
                                    input logic [6:0] f7, output logic [4:0] code,
                                    output bit md, output bit ill);
        int r_map [8];
        int b_map [8];
        r_map = '{0, 7, 5, 6, 4, 8, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND
        b_map = '{1, 1, -1, -1, 5, 5, 6, 6};
        code = 5'd0; md = 1'b0; ill = 1'b0;
        case (o)
            7'h03, 7'h23, 7'h17, 7'h6F, 7'h67: code = 5'd0;
            7'h37: code = 5'd10;
            7'h63: if (b_map[f3] < 0) ill = 1'b1; else code = 5'(b_map[f3]);
            7'h33: begin
                if (f7 == 7'h00) code = 5'(r_map[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) code = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) code = 5'd9;
                else if (f7 == 7'h01 && m_on) begin code = 5'(11 + int'(f3)); md = 1'b1; end
                else ill = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (f7 == 7'h00) code = 5'(r_map[f3]);
                    else if (f3 == 3'd5 && f7 == 7'h20) code = 5'd9;
                    else ill = 1'b1;
                end else begin
                    code = 5'(r_map[f3]);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) code = 5'd0;
    endfunction

    task automatic drive(input bit r, input bit s, input logic [6:0] o,
                         input logic [2:0] f3, input logic [6:0] f7);
        exp_t x;
        int   e;
        @(negedge clk);
        reset = r; start = s; op = o; funct3 = f3; funct7 = f7;
        e = edge_cnt + 1;
        last_e = e;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                next_free[d] = e + 1;
            end else if (s && e >= next_free[d]) begin
                ref_dec(en_m[d], o, f3, f7, x.code, x.md, x.ill);
                x.acc    = e;
                x.done_e = x.md ? e + (f3[2] ? n_div[d] : n_mul[d]) : e;
                sbq[d].push_back(x);
                next_free[d] = x.done_e + 1;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127));
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", nm, d, edge_cnt, act, exp);
        end
    endtask

    // Stimulus: directed scenarios, then randomized traffic, then a drain
    initial begin
        int         sel;
        logic [6:0] o, f7;
        int         ops [10];
        ops = '{'h03, 'h23, 'h17, 'h6F, 'h67, 'h37, 'h63, 'h33, 'h13, 'h33};
        reset = 1'b1; start = 1'b0; op = '0; funct3 = '0; funct7 = '0;
        for (int d = 0; d < 2; d++) next_free[d] = 0;

        drive(1'b1, 1'b0, 7'h00, 3'd0, 7'h00);
        drive(1'b1, 1'b0, 7'h00, 3'd0, 7'h00);
        drive(1'b0, 1'b1, 7'h33, 3'd0, 7'h20);   // SUB
        idle();
        drive(1'b0, 1'b1, 7'h13, 3'd0, 7'h20);   // ADDI, funct7 ignored
        idle();
        drive(1'b0, 1'b1, 7'h63, 3'd6, 7'h00);   // BLTU -> SLTU
        idle();
        drive(1'b0, 1'b1, 7'h33, 3'd4, 7'h01);   // DIV
        repeat (3) idle();
        drive(1'b0, 1'b1, 7'h33, 3'd0, 7'h00);   // ignored while busy
        for (int i = 0; i < 40 && last_e + 1 < next_free[0]; i++) idle();
        drive(1'b0, 1'b1, 7'h33, 3'd0, 7'h01);   // MUL
        for (int i = 0; i < 40 && last_e + 1 < next_free[0]; i++) idle();
        drive(1'b0, 1'b1, 7'h33, 3'd7, 7'h00);   // back-to-back in the done cycle
        idle();
        drive(1'b0, 1'b1, 7'h33, 3'd5, 7'h01);   // DIVU, reset partway through
        repeat (9) idle();
        drive(1'b1, 1'b0, 7'h00, 3'd0, 7'h00);
        drive(1'b0, 1'b1, 7'h33, 3'd0, 7'h00);   // ADD right after reset
        repeat (2) idle();

        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 10);
            o   = (sel == 10) ? 7'($urandom) : 7'(ops[sel]);
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, o,
                  3'($urandom), f7);
        end

        for (int i = 0; i < 40 && (last_e + 1 < next_free[0] || last_e + 1 < next_free[1]); i++) idle();
        repeat (2) idle();
        stim_done = 1'b1;
    end

    // Monitor: compare every output of both instances against the prediction
    initial begin
        exp_t       f;
        bit         has, upd;
        int         e;
        logic [7:0] act_code;
        forever begin
            @(posedge clk);
            edge_cnt = edge_cnt + 1;
            #1;
            e = edge_cnt;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    sbq[d].delete();
                    held_code[d] = 5'd0;
                    held_md[d]   = 1'b0;
                    held_ill[d]  = 1'b0;
                end
                has = sbq[d].size() > 0;
                if (has) f = sbq[d][0];
                upd = has && e >= f.acc;
                act_code = (d == 0) ? {3'b000, ctrl0} : {1'b0, ctrl1};
                chk("alu_ctrl",  d, 32'(act_code),  32'(upd ? f.code : held_code[d]));
                chk("is_muldiv", d, 32'(mdiv_o[d]), 32'(upd ? f.md : held_md[d]));
                chk("illegal",   d, 32'(ill_o[d]),  32'(upd ? f.ill : held_ill[d]));
                chk("done",      d, 32'(done_o[d]), 32'(has && e == f.done_e));
                chk("busy",      d, 32'(busy_o[d]), 32'(has && f.md && e >= f.acc && e < f.done_e));
                chk("md_start",  d, 32'(mds_o[d]),  32'(has && f.md && e == f.acc));
                if (has && e == f.done_e) begin
                    held_code[d] = f.code;
                    held_md[d]   = f.md;
                    held_ill[d]  = f.ill;
                    void'(sbq[d].pop_front());
                end
            end
            if (stim_done) begin
                for (int d = 0; d < 2; d++) chk("pending_ops", d, 32'(sbq[d].size()), 32'd0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised successor to the combinational ALU decoder in the multi-cycle RV32 core.
- Decodes op/funct3/funct7 into a wide ALU control code covering full RV32I ALU usage and, optionally, the RV32M extension.
- Runs a small sequencer that holds the code stable, launches the iterative mul/div unit and reports busy/done to the main controller FSM.
- Sits between the main controller (Execute state) and the ALU / muldiv datapath.

Parameters:
CTRL_W, 5, width of alu_ctrl; must be >=5; bits above [4:0] always 0
ENABLE_M, 1, 1 = decode RV32M ops; 0 = funct7 0000001 on op 0110011 is illegal
MUL_CYCLES, 4, busy cycles for MUL/MULH/MULHSU/MULHU (>=1)
DIV_CYCLES, 32, busy cycles for DIV/DIVU/REM/REMU (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  controller requests decode of current instruction (sampled only in IDLE)
op  in  7  instruction opcode [6:0]
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
alu_ctrl  out  CTRL_W  registered ALU operation code
is_muldiv  out  1  registered: accepted op is an M-extension op
md_start  out  1  one-cycle pulse launching the muldiv unit
busy  out  1  high while the muldiv op is in flight; controller stalls
done  out  1  one-cycle pulse: alu_ctrl and result path valid
illegal  out  1  registered: accepted op is unsupported; valid with done

Behaviour:
- Reset (synchronous, any state): state=IDLE, cnt=0, alu_ctrl=0 (ADD), is_muldiv=0, md_start=0, busy=0, done=0, illegal=0.
- Encodings (alu_ctrl[4:0]):
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
  - MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18.
- Decode rules:
  - lw 0000011, sw 0100011, auipc 0010111, jal 1101111, jalr 1100111 -> ADD.
  - lui 0110111 -> PASSB.
  - Branch 1100011: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
  - R-type 0110011, funct7 0000000: standard funct3 map (000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND).
  - R-type 0110011, funct7 0100000: funct3 000 -> SUB, 101 -> SRA, others illegal.
  - R-type 0110011, funct7 0000001 with ENABLE_M=1: funct3 000..111 -> MUL..REMU in order. Any other funct7 -> illegal.
  - I-type 0010011: never SUB; funct7 ignored except shifts. 001 requires funct7=0000000; 101 gives SRL for funct7=0000000 and SRA for 0100000; other funct7 on shifts -> illegal.
  - Any other opcode -> illegal.
  - On illegal: alu_ctrl=ADD, illegal=1.
- FSM states: IDLE, RUN.
  - IDLE, start=0: hold all registered outputs; done=0, md_start=0.
  - IDLE, start=1, non-muldiv or illegal: next cycle alu_ctrl/illegal/is_muldiv updated, done=1 (latency 1), stay IDLE.
  - IDLE, start=1, muldiv op: next cycle alu_ctrl updated, is_muldiv=1, md_start=1, busy=1, cnt=N-1 (N=MUL_CYCLES or DIV_CYCLES); go RUN.
  - RUN: busy=1, md_start=0. If cnt==0: next state IDLE, busy=0, done=1. Else cnt decrements.
- Timing for muldiv: start accepted at edge t -> busy high for exactly N cycles, done in cycle t+N+1.
- start while in RUN or with busy=1 is ignored; no queueing. Op inputs are sampled only at the accepting edge; later changes have no effect.
- alu_ctrl, is_muldiv and illegal hold their value until the next accepted start.
- done and md_start are never high in the same cycle. done is never high while busy=1.
- Reset asserted mid-RUN: outputs go to reset values on the next edge and no done is emitted.
- cnt width: clog2(max(MUL_CYCLES, DIV_CYCLES)), minimum 1 bit.

Decomposition:
- Shared package alu_pkg: ALU op encodings, opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), FUNCT7 constants, FSM state enum.
- Sub-module alu_op_decode: purely combinational (op, funct3, funct7, ENABLE_M) -> (code, is_muldiv, is_div, illegal).
- alu_ctrl_seq holds the registers, counter and FSM.

Test Plan:
- Reset held 2 cycles mid-stream -> alu_ctrl=0, busy=0, done=0, illegal=0, md_start=0.
- start with op=0110011, f3=000, f7=0100000 -> next cycle alu_ctrl=1 (SUB), done=1, busy=0. Same with op=0010011 -> alu_ctrl=0 (ADD). Branch f3=110 -> alu_ctrl=6 (SLTU).
- ENABLE_M=1, DIV_CYCLES=32, start with op=0110011, f7=0000001, f3=100:
  - md_start=1 for one cycle, busy=1 for 32 cycles, done=1 at cycle 33, alu_ctrl=15.
  - Second start at cycle 5 is ignored (no extra done).
- MUL_CYCLES=4, f3=000 -> busy 4 cycles, done at cycle 5, alu_ctrl=11. Back-to-back start in the done cycle is accepted.
- ENABLE_M=0, same MUL op -> illegal=1, done=1 next cycle, md_start never asserted, alu_ctrl=0.
- Reset asserted at cycle 10 of a DIV -> busy=0 next cycle, no done. A new ADD start after reset gives done in 1 cycle.
